dmem_responder: RTL

Data-memory responder: the slave end of the core's data-memory port (mem_d_we/mem_d_wa/mem_d_wd/mem_d_rd), sitting outside the `riscv` core, which is the initiator. It serves a word RAM plus a small MMIO window: a console transmit FIFO drained over a ready/valid byte stream, a status register and a free-running cycle counter. The core's memory stage is single-cycle, so reads are combinational and writes commit on the clock edge.

---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_responder_tx_fifo.sv | 67 ++++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS bit positions and the default MMIO window base.
package dmem_pkg;

  // Register offsets within the MMIO window, selected by address bits [3:2].
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS register bit positions; the FIFO count sits in the low bits.
  localparam int ST_FULL  = 8;
  localparam int ST_EMPTY = 9;
  localparam int ST_OVF   = 16;

  // Default base of the 16-byte MMIO window (low 4 bits must be zero).
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

  // True when a byte address falls inside the 16-byte MMIO window at base.
  function automatic logic in_mmio_window(input logic [31:0] addr,
                                          input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory port of the core plus the console byte stream. The master side
// is the core/sink pair driving requests and tx_ready; the slave side is the
// responder.
interface dmem_responder_if;

  logic        mem_d_we;
  logic [31:0] mem_d_wa;
  logic [31:0] mem_d_wd;
  logic [31:0] mem_d_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_d_we,
    output mem_d_wa,
    output mem_d_wd,
    output tx_ready,
    input  mem_d_rd,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  mem_d_we,
    input  mem_d_wa,
    input  mem_d_wd,
    input  tx_ready,
    output mem_d_rd,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the console stream. A push while full is
// still accepted if a pop happens in the same cycle (the freed slot is reused);
// otherwise it is dropped and reported on the drop output for one cycle.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    storage [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_COUNT);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Head byte is forced to zero while empty so the stream never shows stale data.
  assign head = empty ? 8'h00 : storage[rd_ptr];

  // Byte storage; written only on an accepted push.
  // NOTE: the storage array has no reset -- contents are only visible through
  // count/empty, so clearing them would cost a reset net on every bit for nothing.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core's single-cycle data-memory port: a word RAM at the
// bottom of the address space and a 16-byte MMIO window holding the console
// TX FIFO, a STATUS register and a free-running CYCLE counter. Reads are
// combinational from mem_d_wa; writes commit on the rising edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  // Address decode
  logic              ram_hit;
  logic              mmio_hit;
  logic [1:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit  = (bus.mem_d_wa < RAM_BYTES);
  assign mmio_hit = !ram_hit && in_mmio_window(bus.mem_d_wa, MMIO_BASE);
  assign reg_sel  = bus.mem_d_wa[3:2];
  assign ram_idx  = bus.mem_d_wa[RAM_AW+1:2];

  // Write strobes
  logic ram_wr;
  logic tx_push;
  logic status_wr;
  logic cycle_wr;
  logic ovf_clear;

  assign ram_wr    = bus.mem_d_we && ram_hit;
  assign tx_push   = bus.mem_d_we && mmio_hit && (reg_sel == OFF_TXDATA);
  assign status_wr = bus.mem_d_we && mmio_hit && (reg_sel == OFF_STATUS);
  assign cycle_wr  = bus.mem_d_we && mmio_hit && (reg_sel == OFF_CYCLE);
  assign ovf_clear = status_wr && bus.mem_d_wd[ST_OVF];

  // Console FIFO
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_drop;
  logic          fifo_pop;

  assign fifo_pop = bus.tx_valid && bus.tx_ready;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus.mem_d_wd[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign bus.tx_data  = fifo_head;
  assign bus.tx_valid = !fifo_empty;

  // Word RAM
  logic [31:0] ram [RAM_WORDS];

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_idx] <= bus.mem_d_wd;
    end
  end

  // Cycle counter and sticky overflow flag
  logic [31:0] cycle;
  logic        overflow;

  // Free-running counter; a CYCLE write loads instead of incrementing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
    end else if (cycle_wr) begin
      cycle <= bus.mem_d_wd;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // Sticky overflow; a clear in the same cycle as a drop wins. The port allows
  // only one access per cycle so both cannot coincide, but the priority keeps
  // the outcome defined if they ever do.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  // STATUS word assembled from live FIFO state and the overflow flag.
  logic [31:0] status_word;

  always_comb begin
    status_word           = '0;
    status_word[CW-1:0]   = fifo_count;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_OVF]   = overflow;
  end

  // Read mux: RAM, then MMIO registers, everything else reads as zero.
  // NOTE: the default assignment at the top guarantees every path drives
  // rdata, so no latch is inferred for unmapped or reserved addresses.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[ram_idx];
    end else if (mmio_hit) begin
      unique case (reg_sel)
        OFF_STATUS: rdata = status_word;
        OFF_CYCLE:  rdata = cycle;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.mem_d_rd = rdata;

endmodule
